// File: rtl/ncpu32k_tlb_inv_ctrl_pkg.sv
// rtl/ncpu32k_tlb_inv_ctrl_pkg.sv - shared widths and sweep FSM encodings for the TLB invalidate controller
`ifndef NCPU32K_CONFIG_H
`define NCPU32K_CONFIG_H
`define NCPU_TLB_AW 7
`define NCPU_DW 32
`define NCPU_TLB_INV_IDLE 2'd0
`define NCPU_TLB_INV_INV 2'd1
`define NCPU_TLB_INV_DONE 2'd2
`endif

package ncpu32k_tlb_inv_ctrl_pkg;

  // TLB index width and data-path width of the MSR write ports
  localparam int TLB_AW = `NCPU_TLB_AW;
  localparam int DW     = `NCPU_DW;

  // Sweep FSM: wait for a request, walk every entry, then announce completion
  typedef enum logic [1:0] {
    INV_IDLE = `NCPU_TLB_INV_IDLE,
    INV_INV  = `NCPU_TLB_INV_INV,
    INV_DONE = `NCPU_TLB_INV_DONE
  } inv_state_e;

  // An all-zero TLBL/TLBH word has its valid bit clear, so it marks the entry invalid
  localparam logic [DW-1:0] TLB_INVALID_ENTRY = '0;

endpackage

// File: rtl/ncpu32k_cell_dff_r.sv
// rtl/ncpu32k_cell_dff_r.sv - generic register cell with synchronous active-low reset
module ncpu32k_cell_dff_r #(
  parameter int            DW         = 1,
  parameter logic [DW-1:0] RST_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // Load d every cycle; reset wins and forces the reset vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VECTOR;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ncpu32k_tlb_inv_ctrl.sv
// rtl/ncpu32k_tlb_inv_ctrl.sv - invalidate-all sweeper sharing the I-MMU TLB write ports with software
module ncpu32k_tlb_inv_ctrl
  import ncpu32k_tlb_inv_ctrl_pkg::*;
#(
  // log2 of the entry count; must be at least 1 and no wider than TLB_AW
  parameter int TLB_NSETS_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inv_valid,
  output logic              inv_ready,
  output logic              inv_done,
  output logic              busy,
  input  logic              sw_tlbl_we,
  input  logic [TLB_AW-1:0] sw_tlbl_idx,
  input  logic [DW-1:0]     sw_tlbl_nxt,
  input  logic              sw_tlbh_we,
  input  logic [TLB_AW-1:0] sw_tlbh_idx,
  input  logic [DW-1:0]     sw_tlbh_nxt,
  output logic              sw_stall,
  output logic              msr_imm_tlbl_we,
  output logic [TLB_AW-1:0] msr_imm_tlbl_idx,
  output logic [DW-1:0]     msr_imm_tlbl_nxt,
  output logic              msr_imm_tlbh_we,
  output logic [TLB_AW-1:0] msr_imm_tlbh_idx,
  output logic [DW-1:0]     msr_imm_tlbh_nxt
);

  localparam logic [TLB_NSETS_LOG2-1:0] CNT_LAST = '1;

  logic [1:0]                state_raw_q;
  logic [1:0]                state_raw_d;
  inv_state_e                state_q;
  inv_state_e                state_d;
  logic [TLB_NSETS_LOG2-1:0] cnt_q;
  logic [TLB_NSETS_LOG2-1:0] cnt_d;
  logic [TLB_AW-1:0]         cnt_idx;

  assign state_q     = inv_state_e'(state_raw_q);
  assign state_raw_d = state_d;
  assign cnt_idx     = TLB_AW'(cnt_q);

  ncpu32k_cell_dff_r #(
    .DW         (2),
    .RST_VECTOR (`NCPU_TLB_INV_IDLE)
  ) u_state_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_raw_d),
    .q     (state_raw_q)
  );

  ncpu32k_cell_dff_r #(
    .DW         (TLB_NSETS_LOG2),
    .RST_VECTOR ('0)
  ) u_cnt_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  // Next state and sweep counter: counter idles at 0 and only runs while sweeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INV_IDLE: begin
        cnt_d = '0;
        if (inv_valid) begin
          state_d = INV_INV;
        end
      end
      INV_INV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = INV_DONE;
        end
      end
      INV_DONE: begin
        cnt_d   = '0;
        state_d = INV_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = INV_IDLE;
      end
    endcase
  end

  // Write-port mux: software passes through when idle, the sweep owns the ports otherwise
  always_comb begin
    inv_ready        = 1'b0;
    inv_done         = 1'b0;
    busy             = 1'b0;
    sw_stall         = 1'b0;
    msr_imm_tlbl_we  = 1'b0;
    msr_imm_tlbl_idx = '0;
    msr_imm_tlbl_nxt = '0;
    msr_imm_tlbh_we  = 1'b0;
    msr_imm_tlbh_idx = '0;
    msr_imm_tlbh_nxt = '0;
    case (state_q)
      INV_INV: begin
        busy             = 1'b1;
        sw_stall         = sw_tlbl_we | sw_tlbh_we;
        msr_imm_tlbl_we  = 1'b1;
        msr_imm_tlbl_idx = cnt_idx;
        msr_imm_tlbl_nxt = TLB_INVALID_ENTRY;
        msr_imm_tlbh_we  = 1'b1;
        msr_imm_tlbh_idx = cnt_idx;
        msr_imm_tlbh_nxt = TLB_INVALID_ENTRY;
      end
      INV_DONE: begin
        busy     = 1'b1;
        inv_done = 1'b1;
        sw_stall = sw_tlbl_we | sw_tlbh_we;
      end
      default: begin
        // Idle (and any unreachable encoding) behaves as a transparent pass-through
        inv_ready        = 1'b1;
        msr_imm_tlbl_we  = sw_tlbl_we;
        msr_imm_tlbl_idx = sw_tlbl_idx;
        msr_imm_tlbl_nxt = sw_tlbl_nxt;
        msr_imm_tlbh_we  = sw_tlbh_we;
        msr_imm_tlbh_idx = sw_tlbh_idx;
        msr_imm_tlbh_nxt = sw_tlbh_nxt;
      end
    endcase
  end

endmodule

// File: tb/tb_ncpu32k_tlb_inv_ctrl.sv
// tb/tb_ncpu32k_tlb_inv_ctrl.sv - directed self-checking bench for the TLB invalidate controller
module tb_ncpu32k_tlb_inv_ctrl;
  import ncpu32k_tlb_inv_ctrl_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              inv_valid;
  logic              inv_ready;
  logic              inv_done;
  logic              busy;
  logic              sw_tlbl_we;
  logic [TLB_AW-1:0] sw_tlbl_idx;
  logic [DW-1:0]     sw_tlbl_nxt;
  logic              sw_tlbh_we;
  logic [TLB_AW-1:0] sw_tlbh_idx;
  logic [DW-1:0]     sw_tlbh_nxt;
  logic              sw_stall;
  logic              msr_imm_tlbl_we;
  logic [TLB_AW-1:0] msr_imm_tlbl_idx;
  logic [DW-1:0]     msr_imm_tlbl_nxt;
  logic              msr_imm_tlbh_we;
  logic [TLB_AW-1:0] msr_imm_tlbh_idx;
  logic [DW-1:0]     msr_imm_tlbh_nxt;

  int n_tests = 0;
  int n_fail  = 0;

  ncpu32k_tlb_inv_ctrl #(.TLB_NSETS_LOG2(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inv_valid        (inv_valid),
    .inv_ready        (inv_ready),
    .inv_done         (inv_done),
    .busy             (busy),
    .sw_tlbl_we       (sw_tlbl_we),
    .sw_tlbl_idx      (sw_tlbl_idx),
    .sw_tlbl_nxt      (sw_tlbl_nxt),
    .sw_tlbh_we       (sw_tlbh_we),
    .sw_tlbh_idx      (sw_tlbh_idx),
    .sw_tlbh_nxt      (sw_tlbh_nxt),
    .sw_stall         (sw_stall),
    .msr_imm_tlbl_we  (msr_imm_tlbl_we),
    .msr_imm_tlbl_idx (msr_imm_tlbl_idx),
    .msr_imm_tlbl_nxt (msr_imm_tlbl_nxt),
    .msr_imm_tlbh_we  (msr_imm_tlbh_we),
    .msr_imm_tlbh_idx (msr_imm_tlbh_idx),
    .msr_imm_tlbh_nxt (msr_imm_tlbh_nxt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and checked 3ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_sw();
    sw_tlbl_we  = 1'b0;
    sw_tlbl_idx = '0;
    sw_tlbl_nxt = '0;
    sw_tlbh_we  = 1'b0;
    sw_tlbh_idx = '0;
    sw_tlbh_nxt = '0;
  endtask

  task automatic drain_to_idle(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #3;
      if (inv_ready) seen = 1'b1;
      else cyc();
    end
    chk(tag, seen, 1'b1);
  endtask

  int pulses[$];

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    inv_valid = 1'b0;
    clr_sw();

    // Reset behaviour: idle pass-through while rst_n is held low
    cyc();
    sw_tlbl_we  = 1'b1;
    sw_tlbl_idx = 7'd5;
    sw_tlbl_nxt = 32'hDEAD_0001;
    #3;
    chk("rst_ready", inv_ready, 1'b1);
    chk("rst_done", inv_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", sw_stall, 1'b0);
    chk("rst_fwd_we", msr_imm_tlbl_we, 1'b1);
    chk("rst_fwd_idx", msr_imm_tlbl_idx, 7'd5);
    chk("rst_fwd_nxt", msr_imm_tlbl_nxt, 32'hDEAD_0001);
    cyc();
    cyc();
    rst_n = 1'b1;
    clr_sw();

    // Software TLBL write in IDLE is forwarded combinationally
    sw_tlbl_we  = 1'b1;
    sw_tlbl_idx = 7'd2;
    sw_tlbl_nxt = 32'h1234_5001;
    #3;
    chk("sw_l_we", msr_imm_tlbl_we, 1'b1);
    chk("sw_l_idx", msr_imm_tlbl_idx, 7'd2);
    chk("sw_l_nxt", msr_imm_tlbl_nxt, 32'h1234_5001);
    chk("sw_l_stall", sw_stall, 1'b0);
    chk("sw_h_we", msr_imm_tlbh_we, 1'b0);
    cyc();
    clr_sw();

    // Basic sweep: entries 0..3 at T+1..T+4, done at T+5, ready at T+6
    inv_valid = 1'b1;
    #3;
    chk("hs_ready", inv_ready, 1'b1);
    cyc();
    inv_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("sw1_l_we", msr_imm_tlbl_we, 1'b1);
      chk("sw1_l_idx", msr_imm_tlbl_idx, 64'(i));
      chk("sw1_l_nxt", msr_imm_tlbl_nxt, 32'h0);
      chk("sw1_h_we", msr_imm_tlbh_we, 1'b1);
      chk("sw1_h_idx", msr_imm_tlbh_idx, 64'(i));
      chk("sw1_h_nxt", msr_imm_tlbh_nxt, 32'h0);
      chk("sw1_busy", busy, 1'b1);
      chk("sw1_ready", inv_ready, 1'b0);
      chk("sw1_done", inv_done, 1'b0);
      cyc();
    end
    #3;
    chk("sw1_done_pulse", inv_done, 1'b1);
    chk("sw1_done_l_we", msr_imm_tlbl_we, 1'b0);
    chk("sw1_done_h_we", msr_imm_tlbh_we, 1'b0);
    chk("sw1_done_busy", busy, 1'b1);
    chk("sw1_done_ready", inv_ready, 1'b0);
    cyc();
    #3;
    chk("sw1_idle_done", inv_done, 1'b0);
    chk("sw1_idle_ready", inv_ready, 1'b1);
    chk("sw1_idle_busy", busy, 1'b0);
    cyc();

    // Held software TLBH write stalls while busy, then lands in the first IDLE cycle
    sw_tlbh_we  = 1'b1;
    sw_tlbh_idx = 7'd3;
    sw_tlbh_nxt = 32'hABCD_0003;
    inv_valid   = 1'b1;
    #3;
    chk("st_hs_stall", sw_stall, 1'b0);
    chk("st_hs_fwd", msr_imm_tlbh_nxt, 32'hABCD_0003);
    cyc();
    inv_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("st_stall", sw_stall, 1'b1);
      if (i < 4) begin
        chk("st_h_idx", msr_imm_tlbh_idx, 64'(i));
        chk("st_h_nxt", msr_imm_tlbh_nxt, 32'h0);
      end else begin
        chk("st_done_h_we", msr_imm_tlbh_we, 1'b0);
      end
      cyc();
    end
    #3;
    chk("st_idle_stall", sw_stall, 1'b0);
    chk("st_idle_we", msr_imm_tlbh_we, 1'b1);
    chk("st_idle_idx", msr_imm_tlbh_idx, 7'd3);
    chk("st_idle_nxt", msr_imm_tlbh_nxt, 32'hABCD_0003);
    cyc();
    clr_sw();

    // Reset mid-sweep aborts without a done pulse; next request restarts at entry 0
    inv_valid = 1'b1;
    #3;
    cyc();
    inv_valid = 1'b0;
    #3;
    chk("ab_idx0", msr_imm_tlbl_idx, 7'd0);
    cyc();
    rst_n = 1'b0;
    #3;
    chk("ab_idx1", msr_imm_tlbl_idx, 7'd1);
    chk("ab_we1", msr_imm_tlbl_we, 1'b1);
    cyc();
    #3;
    chk("ab_we_off", msr_imm_tlbl_we, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_ready", inv_ready, 1'b1);
    chk("ab_done", inv_done, 1'b0);
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("ab_no_done", inv_done, 1'b0);
      chk("ab_no_we", msr_imm_tlbh_we, 1'b0);
      cyc();
    end
    inv_valid = 1'b1;
    #3;
    cyc();
    inv_valid = 1'b0;
    #3;
    chk("ab_restart_we", msr_imm_tlbl_we, 1'b1);
    chk("ab_restart_idx", msr_imm_tlbl_idx, 7'd0);
    cyc();
    cyc();
    cyc();
    cyc();
    #3;
    chk("ab_restart_done", inv_done, 1'b1);
    cyc();
    drain_to_idle("ab_drain");
    cyc();

    // inv_valid held high: done pulses every N+2 = 6 cycles
    inv_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (inv_done) pulses.push_back(c);
      cyc();
    end
    inv_valid = 1'b0;
    chk("bb_npulses", pulses.size(), 6);
    for (int k = 0; k < pulses.size() && k < 6; k++) begin
      chk("bb_pulse_at", pulses[k], 64'(5 + 6 * k));
    end
    drain_to_idle("bb_drain");
    cyc();

    // Software write in the handshake cycle is forwarded, then overwritten by the sweep
    sw_tlbl_we  = 1'b1;
    sw_tlbl_idx = 7'd1;
    sw_tlbl_nxt = 32'h0000_0055;
    inv_valid   = 1'b1;
    #3;
    chk("ow_fwd_we", msr_imm_tlbl_we, 1'b1);
    chk("ow_fwd_idx", msr_imm_tlbl_idx, 7'd1);
    chk("ow_fwd_nxt", msr_imm_tlbl_nxt, 32'h0000_0055);
    chk("ow_fwd_stall", sw_stall, 1'b0);
    cyc();
    clr_sw();
    inv_valid = 1'b0;
    #3;
    chk("ow_t1_idx", msr_imm_tlbl_idx, 7'd0);
    cyc();
    #3;
    chk("ow_t2_we", msr_imm_tlbl_we, 1'b1);
    chk("ow_t2_idx", msr_imm_tlbl_idx, 7'd1);
    chk("ow_t2_nxt", msr_imm_tlbl_nxt, 32'h0);
    cyc();
    drain_to_idle("ow_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ncpu32k_tlb_inv_ctrl.md
NCPU32K_TLB_INV_CTRL -- requirements
Module: ncpu32k_tlb_inv_ctrl

Interface
REQ-001 SHALL have parameter TLB_NSETS_LOG2, default 2, meaning log2 of the number of TLB entries (N = 1<<TLB_NSETS_LOG2); TLB_NSETS_LOG2 <= `NCPU_TLB_AW.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port inv_valid, input, 1 bit: invalidate-all request presented.
REQ-005 SHALL have port inv_ready, output, 1 bit: controller can accept an invalidate request.
REQ-006 SHALL have port inv_done, output, 1 bit: one-cycle pulse when invalidation completes.
REQ-007 SHALL have port busy, output, 1 bit: a sweep is in progress (state INV or DONE).
REQ-008 SHALL have ports sw_tlbl_we (1), sw_tlbl_idx (`NCPU_TLB_AW) and sw_tlbl_nxt (`NCPU_DW), inputs: software TLBL write from the MSR unit.
REQ-009 SHALL have ports sw_tlbh_we (1), sw_tlbh_idx (`NCPU_TLB_AW) and sw_tlbh_nxt (`NCPU_DW), inputs: software TLBH write.
REQ-010 SHALL have port sw_stall, output, 1 bit: a software write this cycle is not accepted and must be held.
REQ-011 SHALL have ports msr_imm_tlbl_we (1), msr_imm_tlbl_idx (`NCPU_TLB_AW) and msr_imm_tlbl_nxt (`NCPU_DW), outputs: TLBL write port driven to the I-MMU.
REQ-012 SHALL have ports msr_imm_tlbh_we (1), msr_imm_tlbh_idx (`NCPU_TLB_AW) and msr_imm_tlbh_nxt (`NCPU_DW), outputs: TLBH write port driven to the I-MMU.

Function
REQ-013 SHALL implement FSM states IDLE, INV and DONE, plus a TLB_NSETS_LOG2-bit sweep counter cnt.
REQ-014 In IDLE: inv_ready=1; sw_stall=0; msr_imm_* outputs equal the corresponding sw_* inputs combinationally.
REQ-015 Handshake inv_valid&inv_ready in IDLE SHALL set state to INV and cnt to 0 on the next edge.
REQ-016 In INV: both we outputs =1; both idx outputs = cnt zero-extended to `NCPU_TLB_AW; both nxt outputs = 0, the invalid entry pattern; cnt increments each cycle.
REQ-017 In INV with cnt==N-1: next state DONE and cnt wraps to 0; the sweep is exactly N cycles.
REQ-018 In DONE: inv_done=1 for exactly one cycle; all we outputs =0; next state IDLE.
REQ-019 In INV and DONE: inv_ready=0; sw_stall = sw_tlbl_we|sw_tlbh_we; software writes are never forwarded.
REQ-020 Latency: for a handshake at cycle T, entry writes occur at T+1..T+N, inv_done at T+N+1, and inv_ready=1 again at T+N+2.
REQ-021 A software write coinciding with the handshake cycle in IDLE SHALL be forwarded that cycle and later overwritten by the sweep.
REQ-022 inv_valid held high through DONE SHALL start a new sweep only after returning to IDLE; there is no back-to-back start.
REQ-023 When inv_valid is low, the FSM SHALL remain in IDLE with cnt held at 0.

Reset
REQ-024 rst_n low at a clock edge SHALL force IDLE and cnt=0, including mid-sweep; the remaining entries are not written.
REQ-025 During and after reset: inv_ready=1, inv_done=0, busy=0, sw_stall=0, and msr_imm_* outputs follow sw_* inputs.

Structure
REQ-026 FSM state encodings (IDLE=2'd0, INV=2'd1, DONE=2'd2) SHALL be defined as macros in the shared ncpu32k_config.h header.
REQ-027 State and counter registers SHALL be instances of the existing ncpu32k_cell_dff_r cell; no other sub-module is required.
REQ-028 The output muxing SHALL be purely combinational from state, cnt and the sw_* inputs.

Verification (N=4)
REQ-029 Reset, then inv_valid pulse at T -> idx 0,1,2,3 with we=1 and nxt=0 at T+1..T+4; inv_done at T+5; inv_ready=1 at T+6.
REQ-030 sw_tlbl_we=1, idx=2, nxt=32'h1234_5001 in IDLE -> msr_imm_tlbl_* equal these inputs the same cycle; sw_stall=0.
REQ-031 sw_tlbh_we=1 held during the sweep -> sw_stall=1 every busy cycle; the write is forwarded in the first IDLE cycle and sw_stall=0 then.
REQ-032 rst_n=0 at T+2 of a sweep -> next cycle IDLE, we=0, inv_done never pulses; a new request then restarts at idx 0.
REQ-033 inv_valid held high continuously -> successive sweeps separated by one DONE and one IDLE cycle; inv_done pulses every N+2 cycles.
REQ-034 Software write to idx 1 in the handshake cycle -> forwarded at T, then overwritten with 0 at T+2.
